mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Two-requester arbiter and sequencer for the single-ported unified instruction/data memory. It is shared by the multi-cycle core (instruction fetch and load/store) and the program loader/debug port. The block accepts one request at a time, drives the memory for exactly one access cycle, and waits out the fixed memory read latency. It then returns a registered completion pulse, with read data, to the winning requester.

## Interface
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width.
- `MEM_LAT`, default 1: memory read latency in cycles (≥1); `mem_rdata` is valid `MEM_LAT` cycles after the `mem_en` cycle.

Ports:
- `clk` in 1: the single clock; all state updates on its rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `cpu_req` in 1: core request; held with its qualifiers until `cpu_gnt`.
- `cpu_we` in 1: core request is a write.
- `cpu_addr` in ADDR_W: core address.
- `cpu_wdata` in DATA_W: core write data.
- `cpu_gnt` out 1: one-cycle pulse; request captured.
- `cpu_done` out 1: one-cycle pulse; access complete.
- `cpu_rdata` out DATA_W: read data, valid while `cpu_done` is high for a read.
- `ldr_req`, `ldr_we`, `ldr_addr`, `ldr_wdata`, `ldr_gnt`, `ldr_done`, `ldr_rdata`: loader port, identical semantics to the core port.
- `mem_en` out 1: memory access strobe.
- `mem_we` out 1: memory write enable, qualified by `mem_en`.
- `mem_addr` out ADDR_W: memory address.
- `mem_wdata` out DATA_W: memory write data.
- `mem_rdata` in DATA_W: memory read data.
- `busy` out 1: high whenever state ≠ IDLE.

## Operation
- States:
  - IDLE: wait for any request.
  - ACCESS: drive the memory for one cycle.
  - WAIT: count read latency.
  - RESP: pulse done.
- IDLE: if either request is high, at the edge select a winner, capture its `we`/`addr`/`wdata` into internal registers, record the winner ID, and go to ACCESS. With no request, stay in IDLE.
- ACCESS:
  - `mem_en`=1, `mem_we`=captured `we`, `mem_addr`/`mem_wdata` from the captured registers.
  - Winner's `gnt`=1.
  - Next state: WAIT for a read, RESP for a write.
- WAIT:
  - Lasts exactly `MEM_LAT` cycles, tracked by a down-counter of width clog2(`MEM_LAT`+1).
  - `mem_rdata` is registered at the edge ending the last WAIT cycle; then go to RESP.
- RESP: winner's `done`=1; its `rdata` holds the registered data (read) or 0 (write). Next state is IDLE.
- Requests are ignored outside IDLE. A requester may drop or change `req` after seeing `gnt`.
- Arbitration without the macro: fixed priority, the loader wins when both request in the same IDLE cycle.
- `rdata` outputs hold their last value outside RESP; they are only meaningful while `done` is high.
- Reset, including during an access:
  - State → IDLE; counter and captured registers → 0.
  - Every output → 0: `gnt`, `done`, `rdata`, all `mem_*`, `busy`.
  - The in-flight access is abandoned and no `done` is issued. A write whose ACCESS cycle already occurred is not undone.
- `mem_*` outputs are 0 in every state other than ACCESS.

## Timing
- Request seen in IDLE at cycle 0:
  - `gnt` and `mem_en` in cycle 1.
  - Read: `done` in cycle 2+`MEM_LAT`. Write: `done` in cycle 2.
- IDLE follows RESP, so back-to-back accesses are spaced as follows:
  - Reads: one accepted per 3+`MEM_LAT` cycles.
  - Writes: one accepted per 3 cycles.
- `gnt`, `done` and `busy` are decoded from registered state. There is no combinational path from `req` to any output.

## Configuration
- `ARB_ROUND_ROBIN_EN` defined:
  - Adds a 1-bit last-winner register; on simultaneous requests, the requester that did not win last is granted.
  - The register updates on every capture, including uncontested ones.
  - Reset value is "loader", so the core wins the first conflict.
- `ARB_ROUND_ROBIN_EN` undefined: loader has fixed priority; no last-winner register exists.

## Structure
- Shared package holds:
  - State encoding constants (IDLE, ACCESS, WAIT, RESP).
  - Requester ID constants (REQ_CPU, REQ_LDR).
- One sub-module, `mem_arb_pick`: combinational winner selection from the two requests plus last-winner. It contains the fixed-priority/round-robin `ifdef`.
- Counter, capture registers and FSM live in the top module.

## Test plan
- `MEM_LAT`=1, core read `addr`=0x10, memory returns 0xDEADBEEF at cycle 2 → `cpu_gnt` at cycle 1, `mem_en`=1/`mem_we`=0 at cycle 1, `cpu_done`=1 with `cpu_rdata`=0xDEADBEEF at cycle 3, `busy` low at cycle 4.
- `MEM_LAT`=3, loader write `addr`=0x40 `wdata`=0x12345678 → `mem_we`=1 at cycle 1 with those values, `ldr_done` at cycle 2, no WAIT cycles.
- Both requesters assert reads in the same IDLE cycle, repeatedly:
  - Macro undefined: loader granted every time and the core starves while the loader holds its request.
  - Macro defined: grants alternate, core first.
- `rst_n` dropped in the WAIT state of a read → all outputs 0 immediately, no `done` after release, next request serviced normally from IDLE.
- Request toggled during ACCESS/WAIT by the other requester → not captured until IDLE; served by a second full transaction with correct data.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared state encoding and requester IDs for the memory port arbiter.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } arb_state_t;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_LDR = 1'b1;

endpackage

// File: rtl/mem_arb_pick.sv
// rtl/mem_arb_pick.sv - combinational winner selection; ARB_ROUND_ROBIN_EN selects alternating priority.
module mem_arb_pick
  import mem_port_arbiter_pkg::*;
(
  input  logic cpu_req,
  input  logic ldr_req,
`ifdef ARB_ROUND_ROBIN_EN
  input  logic last_id,
`endif
  output logic any_req,
  output logic winner
);

  always_comb begin
    any_req = cpu_req | ldr_req;
`ifdef ARB_ROUND_ROBIN_EN
    // On a conflict the requester that lost the previous capture goes first.
    if (cpu_req && ldr_req) begin
      winner = (last_id == REQ_LDR) ? REQ_CPU : REQ_LDR;
    end else begin
      winner = ldr_req ? REQ_LDR : REQ_CPU;
    end
`else
    winner = ldr_req ? REQ_LDR : REQ_CPU;
`endif
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-port arbiter/sequencer for the single-ported unified memory.
// ARB_ROUND_ROBIN_EN enables round-robin arbitration (default: loader has fixed priority).
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_done,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              ldr_req,
  input  logic              ldr_we,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [DATA_W-1:0] ldr_wdata,
  output logic              ldr_gnt,
  output logic              ldr_done,
  output logic [DATA_W-1:0] ldr_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int CNT_W = $clog2(MEM_LAT + 1);

  arb_state_t        state, state_nx;
  logic [CNT_W-1:0]  cnt;
  logic              cap_we;
  logic [ADDR_W-1:0] cap_addr;
  logic [DATA_W-1:0] cap_wdata;
  logic              cap_id;
  logic              any_req;
  logic              pick_id;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_id;

  mem_arb_pick u_pick (
    .cpu_req (cpu_req),
    .ldr_req (ldr_req),
    .last_id (last_id),
    .any_req (any_req),
    .winner  (pick_id)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_id <= REQ_LDR;
    end else if (state == IDLE && any_req) begin
      last_id <= pick_id;
    end
  end
`else
  mem_arb_pick u_pick (
    .cpu_req (cpu_req),
    .ldr_req (ldr_req),
    .any_req (any_req),
    .winner  (pick_id)
  );
`endif

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (any_req) state_nx = ACCESS;
      ACCESS:  state_nx = cap_we ? RESP : WAIT;
      WAIT:    if (cnt == CNT_W'(1)) state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      cap_we    <= 1'b0;
      cap_addr  <= '0;
      cap_wdata <= '0;
      cap_id    <= REQ_CPU;
      cpu_rdata <= '0;
      ldr_rdata <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (any_req) begin
            cap_id    <= pick_id;
            cap_we    <= (pick_id == REQ_LDR) ? ldr_we    : cpu_we;
            cap_addr  <= (pick_id == REQ_LDR) ? ldr_addr  : cpu_addr;
            cap_wdata <= (pick_id == REQ_LDR) ? ldr_wdata : cpu_wdata;
          end
        end
        ACCESS: begin
          // Writes complete with zero read data; reads start the latency count.
          if (cap_we) begin
            if (cap_id == REQ_LDR) ldr_rdata <= '0;
            else                   cpu_rdata <= '0;
          end else begin
            cnt <= CNT_W'(MEM_LAT);
          end
        end
        WAIT: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            if (cap_id == REQ_LDR) ldr_rdata <= mem_rdata;
            else                   cpu_rdata <= mem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state != IDLE);
  assign mem_en    = (state == ACCESS);
  assign mem_we    = mem_en & cap_we;
  assign mem_addr  = mem_en ? cap_addr  : '0;
  assign mem_wdata = mem_en ? cap_wdata : '0;
  assign cpu_gnt   = mem_en & (cap_id == REQ_CPU);
  assign ldr_gnt   = mem_en & (cap_id == REQ_LDR);
  assign cpu_done  = (state == RESP) & (cap_id == REQ_CPU);
  assign ldr_done  = (state == RESP) & (cap_id == REQ_LDR);

endmodule
